// File: rtl/shift_add_mult8.sv
// Sequential unsigned shift-and-add multiplier driving an external ripple-carry adder.
// One adder pass per clock; the 16-bit product is registered on entry to DONE.
module shift_add_mult8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, q, m;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] iter_val;

  // {cout,sum,q} shifted right by one: carry lands in the accumulator MSB
  assign iter_val = {add_cout, add_sum, q[WIDTH-1:1]};
  assign add_a    = acc;
  assign add_cin  = 1'b0;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_b     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        add_b = q[0] ? m : '0;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          {acc, q} <= iter_val;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) product <= iter_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed bench for shift_add_mult8 with a behavioural 8-bit adder beside it.
module tb_shift_add_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [8:0]  sum9;

  int checks   = 0;
  int failures = 0;

  int         busy_cnt, done_cnt, done_k, done_k2;
  logic       saw_cout;
  logic [7:0] addb_log [0:19];
  logic [15:0] prod_at_done, prod_at_done2, prod_k9, prod_k17;
  logic       busy_k9, done_k9;

  shift_add_mult8 #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  assign add_sum  = sum9[7:0];
  assign add_cout = sum9[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; k counts negedges after the accepting edge E0.
  task automatic run_mult(input logic [7:0] ta, input logic [7:0] tb_v, input int inj_k);
    busy_cnt = 0; done_cnt = 0; done_k = -1; saw_cout = 1'b0;
    prod_at_done = 16'hxxxx;
    start = 1'b1; a = ta; b = tb_v;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      addb_log[k] = add_b;
      if (busy) busy_cnt++;
      if (busy && add_cout) saw_cout = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          prod_at_done = product;
        end
      end
      if (k == 0) start = 1'b0;
      if (k == inj_k) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (k == inj_k + 1) start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_mult(8'h0D, 8'h0B, -1);
    chk("m0D0B_busy_cycles", busy_cnt, 8);
    chk("m0D0B_done_k", done_k, 8);
    chk("m0D0B_done_cnt", done_cnt, 1);
    chk("m0D0B_prod_at_done", prod_at_done, 16'h008F);
    chk("m0D0B_prod_hold", product, 16'h008F);

    run_mult(8'hFF, 8'hFF, -1);
    chk("mFFFF_product", product, 16'hFE01);
    chk("mFFFF_saw_cout", saw_cout, 1);

    run_mult(8'h80, 8'h02, -1);
    chk("m8002_product", product, 16'h0100);
    chk("m8002_addb_it1", addb_log[0], 8'h00);
    chk("m8002_addb_it2", addb_log[1], 8'h80);

    run_mult(8'h00, 8'hA5, -1);
    chk("m00A5_product", product, 16'h0000);

    run_mult(8'h03, 8'h05, 3);
    chk("ignore_product", product, 16'h000F);
    chk("ignore_done_cnt", done_cnt, 1);
    chk("ignore_busy_cycles", busy_cnt, 8);
    chk("ignore_done_k", done_k, 8);

    // Asynchronous reset between edges while running 0xFF*0xFF
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_add_a_nonzero", (add_a != 8'h00), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_product", product, 0);
    chk("async_rst_add_a", add_a, 0);
    chk("async_rst_add_b", add_b, 0);
    chk("async_rst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_done", done, 0);
    run_mult(8'h07, 8'h09, -1);
    chk("m0709_product", prod_at_done, 16'h003F);
    chk("m0709_done_k", done_k, 8);
    chk("m0709_done_cnt", done_cnt, 1);

    // Back-to-back with start held high
    done_k = -1; done_k2 = -1;
    prod_at_done = '0; prod_at_done2 = '0;
    start = 1'b1; a = 8'h10; b = 8'h10;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin a = 8'h02; b = 8'h03; end
      if (k == 9) begin busy_k9 = busy; done_k9 = done; prod_k9 = product; end
      if (k == 17) prod_k17 = product;
      if (done) begin
        if (done_k < 0) begin done_k = k; prod_at_done = product; end
        else if (done_k2 < 0) begin done_k2 = k; prod_at_done2 = product; end
      end
      if (k == 10) start = 1'b0;
    end
    chk("b2b_done1_k", done_k, 8);
    chk("b2b_prod1", prod_at_done, 16'h0100);
    chk("b2b_idle_busy", busy_k9, 0);
    chk("b2b_idle_done", done_k9, 0);
    chk("b2b_idle_prod", prod_k9, 16'h0100);
    chk("b2b_hold_prod", prod_k17, 16'h0100);
    chk("b2b_done2_k", done_k2, 18);
    chk("b2b_prod2", prod_at_done2, 16'h0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
